// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if: instruction and data memory req/ack buses of the multi-cycle core
interface mips_multicycle_core_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core with req/ack instruction and data memory ports
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_core_if.master bus,
  output logic                   retire,
  output logic                   halt,
  output logic [31:0]            dbg_pc
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_q, state_d;
  logic run_q;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] rf_q [32];
  logic rf_we;
  logic [4:0] rf_wa;
  logic [31:0] rf_wd, imm, pc4, alu_r;
  logic [5:0] op, fn;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, legal;
  assign op      = ir_q[31:26];
  assign fn      = ir_q[5:0];
  assign imm     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc4     = pc_q + 32'd4;
  assign is_r    = op == 6'h00;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_addi = op == 6'h08;
  assign is_j    = op == 6'h02;
  assign legal   = (is_r && ir_q[10:6] == 5'd0 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                   || is_lw || is_sw || is_beq || is_addi || is_j;
  assign alu_r   = !is_r       ? a_q + imm :
                   fn == 6'h22 ? a_q - b_q :
                   fn == 6'h24 ? a_q & b_q :
                   fn == 6'h25 ? a_q | b_q :
                   fn == 6'h2A ? {31'd0, $signed(a_q) < $signed(b_q)} : a_q + b_q;
  assign rf_wa          = is_r ? ir_q[15:11] : ir_q[20:16];
  assign rf_wd          = is_lw ? mdr_q : alu_q;
  assign bus.imem_addr  = pc_q[ADDR_W-1:0];
  assign bus.dmem_addr  = alu_q[ADDR_W-1:0];
  assign bus.dmem_wdata = b_q;
  assign halt           = state_q == HALT;
  assign dbg_pc         = pc_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_d        = alu_q;
    mdr_d        = mdr_q;
    rf_we        = 1'b0;
    retire       = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    case (state_q)
      FETCH: if (run_q) begin
        if (pc_q[1:0] != 2'b00) state_d = HALT;
        else begin
          bus.imem_req = 1'b1;
          if (bus.imem_ack) begin
            ir_d    = bus.imem_rdata;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        a_d = rf_q[ir_q[25:21]];
        b_d = rf_q[ir_q[20:16]];
        if (!legal) begin
          state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
          pc_d    = HALT_ON_ILLEGAL ? pc_q : pc4;
          retire  = !HALT_ON_ILLEGAL;
        end else if (is_j) begin
          pc_d    = {pc4[31:28], ir_q[25:0], 2'b00};
          retire  = 1'b1;
          state_d = FETCH;
        end else state_d = EXEC;
      end
      EXEC: begin
        alu_d = alu_r;
        if (is_beq) begin
          pc_d    = a_q == b_q ? pc4 + {imm[29:0], 2'b00} : pc4;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_lw || is_sw) state_d = alu_r[1:0] != 2'b00 ? HALT : MEM;
        else state_d = WB;
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_sw;
        if (bus.dmem_ack) begin
          mdr_d   = bus.dmem_rdata;
          pc_d    = is_sw ? pc4 : pc_q;
          retire  = is_sw;
          state_d = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_d    = pc4;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
  end
endmodule
